// File: rtl/ifu_prefetch.sv
// Purpose: sequential-path instruction prefetcher that keeps several AXI-lite reads
//          in flight and queues the returned instructions in front of the IDU.
// Latency: first AR one cycle after reset release; a pushed instruction is at the head
//          on the next cycle.
// Backpressure: send_ready stalls the queue head; new ARs stop once outstanding reads
//          plus queued entries would exceed the queue depth, so rready never drops.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   redirect_valid, redirect_pc      flush the queue and restart fetch at redirect_pc
//   araddr, arvalid, arready         AXI read-address channel
//   rdata, rresp, rvalid, rready     AXI read-data channel
//   send_valid, send_ready           queue head handshake toward the IDU
//   instruction, pc_ifu_to_idu       head entry payload
//   fetch_fault                      head entry returned a bus error
module ifu_prefetch #(
  parameter int              ADDR_W          = 32,
  parameter int              DATA_W          = 32,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_PC      = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic              send_valid,
  input  logic              send_ready,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] pc_ifu_to_idu,
  output logic              fetch_fault
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] MAX_OS = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] DEPTH  = CNT_W'(FIFO_DEPTH);

  logic [DATA_W-1:0] q_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] q_pc   [FIFO_DEPTH];
  logic              q_flt  [FIFO_DEPTH];

  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count, outstanding, drop_cnt;
  logic [ADDR_W-1:0] fetch_pc, resp_pc;
  logic              halted;
  // Set while the AR on the bus was issued before a redirect: its handshake must not
  // advance fetch_pc, which already points at the redirect target.
  logic              stale_ar;

  logic ar_hs, r_hs, push, pop, issue_ok;

  assign ar_hs    = arvalid && arready;
  assign r_hs     = rvalid && rready;
  assign push     = r_hs && (drop_cnt == '0) && !redirect_valid;
  assign pop      = send_valid && send_ready && !redirect_valid;
  // Credit rule: every read in flight owns a queue slot, so a response always fits.
  assign issue_ok = !halted && (outstanding < MAX_OS) && ((outstanding + count) < DEPTH);

  assign send_valid    = (count != '0);
  assign instruction   = send_valid ? q_data[rd_ptr] : '0;
  assign pc_ifu_to_idu = send_valid ? q_pc[rd_ptr]   : '0;
  assign fetch_fault   = send_valid ? q_flt[rd_ptr]  : 1'b0;

  // Queue storage carries no reset; the head outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= rdata;
      q_pc[wr_ptr]   <= resp_pc;
      q_flt[wr_ptr]  <= (rresp != 2'b00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arvalid     <= 1'b0;
      araddr      <= RESET_PC;
      rready      <= 1'b0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      halted      <= 1'b0;
      stale_ar    <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      rready      <= 1'b1;
      // The bus-side count tracks every handshake, redirect or not.
      outstanding <= outstanding + CNT_W'(ar_hs) - CNT_W'(r_hs);

      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        halted   <= 1'b0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        // Everything still owed by the bus after this edge, including an AR that is
        // presented but not yet accepted (arvalid covers both accepted and pending).
        drop_cnt <= outstanding + CNT_W'(arvalid) - CNT_W'(r_hs);
        stale_ar <= arvalid && !arready;
        if (ar_hs) begin
          arvalid <= 1'b0;
        end
      end else begin
        if (ar_hs) begin
          arvalid  <= 1'b0;
          stale_ar <= 1'b0;
          if (!stale_ar) begin
            fetch_pc <= fetch_pc + ADDR_W'(4);
          end
        end else if (!arvalid && issue_ok) begin
          arvalid <= 1'b1;
          araddr  <= fetch_pc;
        end

        if (r_hs) begin
          if (drop_cnt != '0) begin
            drop_cnt <= drop_cnt - CNT_W'(1);
          end else begin
            resp_pc <= resp_pc + ADDR_W'(4);
            if (rresp != 2'b00) begin
              halted <= 1'b1;
            end
          end
        end

        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Purpose: directed bench for ifu_prefetch with a simple in-order memory model.
// Latency: memory answers a fixed number of cycles after each AR handshake.
// Backpressure: send_ready and arready are scripted per vector.
module tb_ifu_prefetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        send_valid;
  logic        send_ready;
  logic [31:0] instruction;
  logic [31:0] pc_ifu_to_idu;
  logic        fetch_fault;

  always #5 clk = ~clk;

  ifu_prefetch #(
    .ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .MAX_OUTSTANDING(3), .RESET_PC(RST_PC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .send_valid(send_valid), .send_ready(send_ready),
    .instruction(instruction), .pc_ifu_to_idu(pc_ifu_to_idu), .fetch_fault(fetch_fault)
  );

  // One record per scenario: scripted inputs, a mid-run spot check, and the expected
  // AR / delivery sequences (first *_old entries run from RST_PC, the rest from new_base).
  typedef struct packed {
    int          lat;       // R handshake this many cycles after the AR handshake
    int          sr_off;    // send_ready low for steps below this
    int          ar_stop;   // arready low once this many ARs were accepted ...
    int          ar_go;     // ... until this step
    int          r1_at;
    logic [31:0] r1_pc;
    int          r2_at;
    logic [31:0] r2_pc;
    logic [31:0] flt_addr;  // address answered with rresp=2 (0: none)
    int          ncyc;
    int          chk_at;
    logic        chk_sv;
    logic        chk_arv;
    int          chk_nar;   // ARs accepted before chk_at
    int          ar_old;
    int          dl_old;
    logic [31:0] new_base;
    int          flt_idx;   // delivery index expected to carry fetch_fault
  } vec_t;

  vec_t vecs [6];

  logic [31:0] mq_addr [$];
  int          mq_due  [$];
  logic [31:0] ar_log  [$];
  logic [31:0] dl_pc   [$];
  logic [31:0] dl_ins  [$];
  logic        dl_flt  [$];
  int          ar_count;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    arready        = 1'b0;
    rdata          = 32'h0;
    rresp          = 2'b00;
    rvalid         = 1'b0;
    send_ready     = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_arvalid"}, 32'(arvalid), 32'h0);
    chk({tag, "_araddr"}, araddr, RST_PC);
    chk({tag, "_rready"}, 32'(rready), 32'h0);
    chk({tag, "_send_valid"}, 32'(send_valid), 32'h0);
    chk({tag, "_instruction"}, instruction, 32'h0);
    chk({tag, "_pc"}, pc_ifu_to_idu, 32'h0);
    chk({tag, "_fetch_fault"}, 32'(fetch_fault), 32'h0);
  endtask

  // Leaves rst_n released right at a falling edge; that edge is step 0.
  task automatic start_reset();
    rst_n = 1'b0;
    idle_inputs();
    mq_addr.delete(); mq_due.delete(); ar_log.delete();
    dl_pc.delete(); dl_ins.delete(); dl_flt.delete();
    ar_count = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs at a falling edge: drives inputs for the next rising edge, then records the
  // handshakes that edge will complete.
  task automatic step(input int k, input vec_t v);
    send_ready     = (k >= v.sr_off);
    redirect_valid = (k == v.r1_at) || (k == v.r2_at);
    redirect_pc    = (k == v.r2_at) ? v.r2_pc : v.r1_pc;
    arready        = (ar_count < v.ar_stop) || (k >= v.ar_go);
    if (mq_addr.size() > 0 && mq_due[0] <= k) begin
      rvalid = 1'b1;
      rdata  = mq_addr[0];
      rresp  = (v.flt_addr != 32'h0 && mq_addr[0] == v.flt_addr) ? 2'd2 : 2'd0;
    end else begin
      rvalid = 1'b0;
      rdata  = 32'h0;
      rresp  = 2'd0;
    end
    #1;
    if (k == v.chk_at) begin
      chk("spot_send_valid", 32'(send_valid), 32'(v.chk_sv));
      chk("spot_arvalid", 32'(arvalid), 32'(v.chk_arv));
      chk("spot_ar_count", ar_count, v.chk_nar);
    end
    if (rvalid && rready) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (arvalid && arready) begin
      mq_addr.push_back(araddr);
      mq_due.push_back(k + v.lat);
      ar_log.push_back(araddr);
      ar_count++;
    end
    if (send_valid && send_ready) begin
      dl_pc.push_back(pc_ifu_to_idu);
      dl_ins.push_back(instruction);
      dl_flt.push_back(fetch_fault);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    logic [31:0] exp_a, exp_p, act;
    start_reset();
    for (int k = 0; k < v.ncyc; k++) begin
      if (k > 0) @(negedge clk);
      step(k, v);
    end
    for (int i = 0; i < 6; i++) begin
      exp_a = (i < v.ar_old) ? RST_PC + 32'(4 * i) : v.new_base + 32'(4 * (i - v.ar_old));
      exp_p = (i < v.dl_old) ? RST_PC + 32'(4 * i) : v.new_base + 32'(4 * (i - v.dl_old));
      act = (i < ar_log.size()) ? ar_log[i] : 32'hFFFF_FFFF;
      chk($sformatf("v%0d_araddr%0d", id, i), act, exp_a);
      act = (i < dl_pc.size()) ? dl_pc[i] : 32'hFFFF_FFFF;
      chk($sformatf("v%0d_pc%0d", id, i), act, exp_p);
      act = (i < dl_ins.size()) ? dl_ins[i] : 32'hFFFF_FFFF;
      chk($sformatf("v%0d_instr%0d", id, i), act, exp_p);
      act = (i < dl_flt.size()) ? 32'(dl_flt[i]) : 32'hFFFF_FFFF;
      chk($sformatf("v%0d_fault%0d", id, i), act, 32'(i == v.flt_idx));
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst");

    //          lat sr  stop go r1  r1_pc         r2  r2_pc         flt_addr      ncyc chk sv    arv   nar ar_old dl_old new_base      flt
    // streaming from reset
    vecs[0] = '{1,  0,  99,  0, -1, 32'h0,        -1, 32'h0,        32'h0,        40,  1,  1'b0, 1'b1, 0,  6,     6,     32'h0,        -1};
    // IDU stalled 22 cycles: four entries fill the queue, then fetch resumes at +0x10
    vecs[1] = '{1,  22, 99,  0, -1, 32'h0,        -1, 32'h0,        32'h0,        50,  20, 1'b1, 1'b0, 4,  6,     6,     32'h0,        -1};
    // redirect with two reads outstanding and one AR pending: three responses dropped
    vecs[2] = '{8,  0,  2,   6, 5,  32'h8000_1000, -1, 32'h0,       32'h0,        90,  6,  1'b0, 1'b1, 2,  3,     0,     32'h8000_1000, -1};
    // redirect in the same cycle as an R handshake
    vecs[3] = '{1,  0,  99,  0, 4,  32'h8000_2000, -1, 32'h0,       32'h0,        40,  5,  1'b0, 1'b0, 2,  2,     1,     32'h8000_2000, -1};
    // bus error on 0x80000008 halts fetch until the redirect
    vecs[4] = '{1,  0,  99,  0, 14, 32'h8000_0100, -1, 32'h0,       32'h8000_0008, 40, 12, 1'b0, 1'b0, 4,  4,     4,     32'h8000_0100, 2};
    // back-to-back redirects: the second target wins
    vecs[5] = '{1,  0,  99,  0, 4,  32'h8000_3000, 5,  32'h8000_4000, 32'h0,      40,  6,  1'b0, 1'b0, 2,  2,     1,     32'h8000_4000, -1};

    for (int i = 0; i < 6; i++) begin
      run_vec(i, vecs[i]);
    end

    // Reset asserted mid-burst with the queue three deep and an AR on the bus.
    start_reset();
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      step(k, vecs[1]);
    end
    @(negedge clk);
    #1;
    chk("mid_pre_arvalid", 32'(arvalid), 32'h1);
    chk("mid_pre_araddr", araddr, 32'h8000_000C);
    chk("mid_pre_send_valid", 32'(send_valid), 32'h1);
    chk("mid_pre_head_pc", pc_ifu_to_idu, RST_PC);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check_reset_outputs("mid_rst");
    start_reset();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      step(k, vecs[0]);
    end
    chk("mid_post_first_ar", (ar_log.size() > 0) ? ar_log[0] : 32'hFFFF_FFFF, RST_PC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
